button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 250000, SHALL be the debounce stability window in clock cycles; legal range 2..2^20-1.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 btn_set_raw  input  1  SHALL be the raw, bouncing, asynchronous "set" push-button.
REQ-005 btn_clr_raw  input  1  SHALL be the raw, bouncing, asynchronous "clear" push-button.
REQ-006 sw_in  input  8  SHALL be the raw, asynchronous slide-switch byte.
REQ-007 byte_strobe  output  1  SHALL be a one-cycle pulse marking one accepted byte.
REQ-008 byte_out  output  8  SHALL be the synchronized switch byte captured at the strobe.
REQ-009 byte_idx  output  3  SHALL be the slot (0..7) of the byte presented with the strobe.
REQ-010 full  output  1  SHALL be high once 8 bytes are accepted since the last reset or clear.
REQ-011 set_held  output  1  SHALL be the debounced level of the set button, for LED display.

Function
REQ-012 btn_set_raw, btn_clr_raw and sw_in SHALL each pass through a 2-flop synchronizer; all other logic SHALL use only the synchronized values.
REQ-013 The set path SHALL be a 4-state FSM: IDLE, ARM, PRESSED, RELEASE, with a 20-bit stability counter.
REQ-014 IDLE: sync set high -> ARM, counter cleared to 0; otherwise stay.
REQ-015 ARM: sync set low -> IDLE; else if counter == DB_CYCLES-1 -> PRESSED; else counter increments.
REQ-016 The ARM->PRESSED transition SHALL be the "debounced press" event.
REQ-017 PRESSED: sync set low -> RELEASE, counter cleared; otherwise stay.
REQ-018 RELEASE: sync set high -> PRESSED with no new press event; else if counter == DB_CYCLES-1 -> IDLE; else counter increments.
REQ-019 set_held SHALL be high exactly while the FSM is in PRESSED or RELEASE.
REQ-020 A 4-bit fill count (0..8) SHALL track accepted bytes; full = (count == 8).
REQ-021 On a debounced press with full low: byte_strobe high for exactly one cycle, byte_out = synchronized sw_in, byte_idx = count[2:0], count increments, all registered on the same edge.
REQ-022 On a debounced press with full high: no strobe, byte_out/byte_idx/count unchanged; FSM still enters PRESSED.
REQ-023 byte_out and byte_idx SHALL hold their values between strobes.
REQ-024 Latency: the first edge sampling btn_set_raw high is edge 1; with the input held stable high, byte_strobe SHALL be high after edge DB_CYCLES+3 and low after edge DB_CYCLES+4.
REQ-025 Any low sample in ARM SHALL restart qualification from IDLE; glitches shorter than DB_CYCLES cycles SHALL never produce a strobe.
REQ-026 One physical press SHALL yield at most one strobe, regardless of the number of bounces in RELEASE.
REQ-027 The clear path SHALL use an identical, independent debounce FSM; its debounced press SHALL set count to 0 and deassert full on the next edge.
REQ-028 If debounced clear and debounced set occur on the same edge, clear SHALL win: count = 0, no strobe, byte_out/byte_idx unchanged.
REQ-029 Clear SHALL NOT alter byte_out or byte_idx.

Reset
REQ-030 While rst_n is low: both FSMs in IDLE, counters 0, synchronizers 0, count 0, byte_strobe 0, byte_out 0x00, byte_idx 0, full 0, set_held 0.
REQ-031 Reset assertion mid-press SHALL abort immediately; after release, a still-held button SHALL requalify from IDLE with the full latency of REQ-024.

Verification (DB_CYCLES = 4)
REQ-032 Clean press: sw_in=0xA5, set held high from edge 1 -> byte_strobe high after edge 7 only, byte_out=0xA5, byte_idx=0, full=0.
REQ-033 Bounce: set toggles high 2 cycles / low 1 cycle for 20 cycles, then held high -> exactly one strobe, occurring 7 edges after the final rising transition.
REQ-034 Fill: 8 clean presses with sw_in=0x10..0x17 -> byte_idx 0..7 in order, full high after the 8th strobe; 9th press -> no strobe, byte_out stays 0x17.
REQ-035 Clear race: full=1, set and clear pressed on the same edge with identical stable timing -> count=0, full=0, no strobe; next press -> byte_idx=0.
REQ-036 Reset mid-press: rst_n pulsed low at edge 5 of a held press -> no strobe; strobe after the 7th edge following rst_n release, byte_idx=0.
REQ-037 Release bounce: after acceptance, set bounces low/high for 3 cycles, then stays low -> no second strobe; set_held falls 4 cycles after the final low sample.

Source files
------------

// File: rtl/button_conditioner.sv
// Debounces a "set" and a "clear" push-button and, on each qualified set press,
// captures the slide-switch byte into one of eight slots.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | button released and stable; waiting for a high sample
// ARM     | button seen high; counting consecutive high samples
// PRESSED | debounced press accepted; waiting for a low sample
// RELEASE | button seen low; counting consecutive low samples
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_set_raw,
    input  logic       btn_clr_raw,
    input  logic [7:0] sw_in,
    output logic       byte_strobe,
    output logic [7:0] byte_out,
    output logic [2:0] byte_idx,
    output logic       full,
    output logic       set_held
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } db_state_t;

    localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

    logic [1:0] set_sync;
    logic [1:0] clr_sync;
    logic [7:0] sw_sync1;
    logic [7:0] sw_sync2;
    logic       set_s;
    logic       clr_s;

    db_state_t   set_state, set_state_nxt;
    db_state_t   clr_state, clr_state_nxt;
    logic [19:0] set_cnt, set_cnt_nxt;
    logic [19:0] clr_cnt, clr_cnt_nxt;
    logic        set_press;
    logic        clr_press;

    logic [3:0]  fill_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_sync <= 2'b00;
            clr_sync <= 2'b00;
            sw_sync1 <= 8'h00;
            sw_sync2 <= 8'h00;
        end else begin
            set_sync <= {set_sync[0], btn_set_raw};
            clr_sync <= {clr_sync[0], btn_clr_raw};
            sw_sync1 <= sw_in;
            sw_sync2 <= sw_sync1;
        end
    end

    assign set_s = set_sync[1];
    assign clr_s = clr_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_state <= IDLE;
            clr_state <= IDLE;
            set_cnt   <= 20'd0;
            clr_cnt   <= 20'd0;
        end else begin
            set_state <= set_state_nxt;
            clr_state <= clr_state_nxt;
            set_cnt   <= set_cnt_nxt;
            clr_cnt   <= clr_cnt_nxt;
        end
    end

    always_comb begin
        set_state_nxt = set_state;
        set_cnt_nxt   = set_cnt;
        set_press     = 1'b0;
        case (set_state)
            IDLE: begin
                if (set_s) begin
                    set_state_nxt = ARM;
                    set_cnt_nxt   = 20'd0;
                end
            end
            ARM: begin
                if (!set_s) begin
                    set_state_nxt = IDLE;
                end else if (set_cnt == DB_LAST) begin
                    set_state_nxt = PRESSED;
                    set_press     = 1'b1;
                end else begin
                    set_cnt_nxt = set_cnt + 20'd1;
                end
            end
            PRESSED: begin
                if (!set_s) begin
                    set_state_nxt = RELEASE;
                    set_cnt_nxt   = 20'd0;
                end
            end
            RELEASE: begin
                // A bounce back high returns to PRESSED without a new press event
                if (set_s) begin
                    set_state_nxt = PRESSED;
                end else if (set_cnt == DB_LAST) begin
                    set_state_nxt = IDLE;
                end else begin
                    set_cnt_nxt = set_cnt + 20'd1;
                end
            end
            default: set_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_state_nxt = clr_state;
        clr_cnt_nxt   = clr_cnt;
        clr_press     = 1'b0;
        case (clr_state)
            IDLE: begin
                if (clr_s) begin
                    clr_state_nxt = ARM;
                    clr_cnt_nxt   = 20'd0;
                end
            end
            ARM: begin
                if (!clr_s) begin
                    clr_state_nxt = IDLE;
                end else if (clr_cnt == DB_LAST) begin
                    clr_state_nxt = PRESSED;
                    clr_press     = 1'b1;
                end else begin
                    clr_cnt_nxt = clr_cnt + 20'd1;
                end
            end
            PRESSED: begin
                if (!clr_s) begin
                    clr_state_nxt = RELEASE;
                    clr_cnt_nxt   = 20'd0;
                end
            end
            RELEASE: begin
                if (clr_s) begin
                    clr_state_nxt = PRESSED;
                end else if (clr_cnt == DB_LAST) begin
                    clr_state_nxt = IDLE;
                end else begin
                    clr_cnt_nxt = clr_cnt + 20'd1;
                end
            end
            default: clr_state_nxt = IDLE;
        endcase
    end

    // Clear has priority over a simultaneous set press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_strobe <= 1'b0;
            byte_out    <= 8'h00;
            byte_idx    <= 3'd0;
            fill_cnt    <= 4'd0;
        end else begin
            byte_strobe <= 1'b0;
            if (clr_press) begin
                fill_cnt <= 4'd0;
            end else if (set_press && !full) begin
                byte_strobe <= 1'b1;
                byte_out    <= sw_sync2;
                byte_idx    <= fill_cnt[2:0];
                fill_cnt    <= fill_cnt + 4'd1;
            end
        end
    end

    assign full     = (fill_cnt == 4'd8);
    assign set_held = (set_state == PRESSED) || (set_state == RELEASE);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DB_CYCLES = 4): expected strobes are queued
// by the stimulus and matched by a negedge monitor against data, slot and edge number.
module tb_button_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_set_raw = 1'b0;
    logic       btn_clr_raw = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic       byte_strobe;
    logic [7:0] byte_out;
    logic [2:0] byte_idx;
    logic       full;
    logic       set_held;

    button_conditioner #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_set_raw (btn_set_raw),
        .btn_clr_raw (btn_clr_raw),
        .sw_in       (sw_in),
        .byte_strobe (byte_strobe),
        .byte_out    (byte_out),
        .byte_idx    (byte_idx),
        .full        (full),
        .set_held    (set_held)
    );

    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  b;
        logic [2:0]  idx;
        int unsigned edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Strobe monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (byte_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe edge=%0d byte_out=0x%0h byte_idx=%0d required=no_strobe",
                         edge_cnt, byte_out, byte_idx);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_byte", 32'(byte_out), 32'(mon_e.b));
                check("strobe_idx",  32'(byte_idx), 32'(mon_e.idx));
                check("strobe_edge", edge_cnt, mon_e.edge_no);
            end
        end
    end

    task automatic press(input logic [7:0] sw, input bit expect_strobe, input logic [2:0] idx);
        @(negedge clk);
        sw_in = sw;
        @(negedge clk);
        btn_set_raw = 1'b1;
        if (expect_strobe) sb.push_back('{sw, idx, edge_cnt + 1 + DB + 2});
        repeat (DB + 6) @(negedge clk);
        check("set_held_pressed", 32'(set_held), 32'd1);
        btn_set_raw = 1'b0;
        repeat (DB + 6) @(negedge clk);
        check("set_held_released", 32'(set_held), 32'd0);
    endtask

    initial begin
        int unsigned last_rise;
        int unsigned k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobe", 32'(byte_strobe), 32'd0);
        check("rst_byte",   32'(byte_out),    32'h00);
        check("rst_idx",    32'(byte_idx),    32'd0);
        check("rst_full",   32'(full),        32'd0);
        check("rst_held",   32'(set_held),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press: strobe after edge 7 of the press
        press(8'hA5, 1'b1, 3'd0);
        check("clean_full", 32'(full), 32'd0);

        // Bounce: H,H,L pattern for 20 cycles then held high
        @(negedge clk);
        sw_in = 8'h3C;
        @(negedge clk);
        last_rise = 0;
        for (int i = 0; i < 20; i++) begin
            btn_set_raw = (i % 3 != 2);
            if (i % 3 == 0) last_rise = edge_cnt + 1;
            @(negedge clk);
        end
        btn_set_raw = 1'b1;
        sb.push_back('{8'h3C, 3'd1, last_rise + DB + 2});
        repeat (DB + 6) @(negedge clk);
        btn_set_raw = 1'b0;
        repeat (DB + 6) @(negedge clk);

        // Release bounce: one strobe only, set_held falls DB cycles after RELEASE entry
        @(negedge clk);
        sw_in = 8'h5A;
        @(negedge clk);
        btn_set_raw = 1'b1;
        sb.push_back('{8'h5A, 3'd2, edge_cnt + 1 + DB + 2});
        repeat (DB + 6) @(negedge clk);
        for (int j = 0; j < 6; j++) begin
            btn_set_raw = (j % 2 == 1);
            @(negedge clk);
        end
        btn_set_raw = 1'b0;
        k = edge_cnt + 1;
        while (edge_cnt < k + 5) @(negedge clk);
        check("rel_held_still", 32'(set_held), 32'd1);
        @(negedge clk);
        check("rel_held_fall", 32'(set_held), 32'd0);
        repeat (DB + 4) @(negedge clk);

        // Clear leaves byte_out/byte_idx untouched
        @(negedge clk);
        btn_clr_raw = 1'b1;
        repeat (DB + 6) @(negedge clk);
        check("clr_byte", 32'(byte_out), 32'h5A);
        check("clr_idx",  32'(byte_idx), 32'd2);
        check("clr_full", 32'(full),     32'd0);
        btn_clr_raw = 1'b0;
        repeat (DB + 6) @(negedge clk);

        // Fill all eight slots from zero
        for (int i = 0; i < 8; i++) begin
            press(8'h10 + 8'(i), 1'b1, 3'(i));
            check("fill_full_progress", 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        press(8'h99, 1'b0, 3'd0);
        check("full_byte_hold", 32'(byte_out), 32'h17);
        check("full_idx_hold",  32'(byte_idx), 32'd7);
        check("full_stays",     32'(full),     32'd1);

        // Clear and set qualify on the same edge: clear wins
        @(negedge clk);
        btn_set_raw = 1'b1;
        btn_clr_raw = 1'b1;
        repeat (DB + 6) @(negedge clk);
        check("race_full", 32'(full),     32'd0);
        check("race_byte", 32'(byte_out), 32'h17);
        check("race_idx",  32'(byte_idx), 32'd7);
        btn_set_raw = 1'b0;
        btn_clr_raw = 1'b0;
        repeat (DB + 6) @(negedge clk);
        press(8'h42, 1'b1, 3'd0);

        // Reset mid-press, button still held afterwards
        @(negedge clk);
        sw_in = 8'h77;
        @(negedge clk);
        btn_set_raw = 1'b1;
        k = edge_cnt + 1;
        while (edge_cnt < k + 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_strobe", 32'(byte_strobe), 32'd0);
        check("midrst_byte",   32'(byte_out),    32'h00);
        check("midrst_idx",    32'(byte_idx),    32'd0);
        check("midrst_held",   32'(set_held),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{8'h77, 3'd0, edge_cnt + 1 + DB + 2});
        repeat (DB + 6) @(negedge clk);
        btn_set_raw = 1'b0;
        repeat (DB + 6) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes actual=%0d_outstanding required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
